// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encodings for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSN     = 32'h0000_0013;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Signals between the fetch stage, the state machine, instruction memory and decode.
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            phase_fetch;
    logic            phase_writeback;
    logic            jump_en;
    logic [XLEN-1:0] jump_addr;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            stall_fetch;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            fetch_fault;

    modport master (
        input  phase_fetch, phase_writeback, jump_en, jump_addr, imem_ack, imem_rdata,
        output imem_req, imem_addr, stall_fetch, inst, pc, pc_plus4, fetch_fault
    );

    modport slave (
        output phase_fetch, phase_writeback, jump_en, jump_addr, imem_ack, imem_rdata,
        input  imem_req, imem_addr, stall_fetch, inst, pc, pc_plus4, fetch_fault
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, handshakes with instruction memory and holds
// the fetched word; a watchdog turns a hung memory into a NOP plus a sticky fault.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              TIMEOUT      = 16
) (
    input logic         clk,
    input logic         rst,
    fetch_stage_if.master bus
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    // The request cycle spent in IDLE already counts toward the limit.
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'((TIMEOUT > 1) ? 1 : 0);

    fetch_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;

    logic            req;
    logic            timeout_hit;
    logic            fetch_only;

    // Simultaneous FETCH and WRITEBACK is illegal; the request is suppressed.
    assign fetch_only  = bus.phase_fetch & ~bus.phase_writeback;
    assign req         = ~rst & ((state_q == ST_WAIT) | fetch_only);
    assign timeout_hit = (TIMEOUT != 0) & (state_q == ST_WAIT) &
                         (cnt_q == CNT_LAST) & ~bus.imem_ack;

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.stall_fetch = ~rst & fetch_only & ~bus.imem_ack & ~timeout_hit;
    assign bus.inst        = inst_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_q + XLEN'(4);
    assign bus.fetch_fault = fault_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        fault_d = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (req && bus.imem_ack) begin
                    inst_d = bus.imem_rdata;
                end else if (req) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_START;
                end
            end
            ST_WAIT: begin
                if (bus.imem_ack) begin
                    inst_d  = bus.imem_rdata;
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    inst_d  = NOP_INSN;
                    fault_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.phase_writeback) begin
            if (bus.jump_en) begin
                pc_d = {bus.jump_addr[XLEN-1:2], 2'b00};
                if (bus.jump_addr[1:0] != 2'b00) begin
                    fault_d = 1'b1;
                end
            end else begin
                pc_d = pc_q + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            inst_q  <= NOP_INSN;
            pc_q    <= RESET_VECTOR;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scoreboarded fetches, PC updates,
// watchdog timeout and reset in the middle of a wait.
module tb_fetch_stage;

    localparam int          XLEN    = 32;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int          NEVER   = 1000;

    logic clk;
    logic rst;

    fetch_stage_if #(.XLEN(XLEN)) bus ();

    fetch_stage #(
        .XLEN        (XLEN),
        .RESET_VECTOR(32'h0000_0000),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] inst_q_sb[$];
    logic [31:0] pc_model;
    logic        fault_model;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.phase_fetch     = 1'b0;
        bus.phase_writeback = 1'b0;
        bus.jump_en         = 1'b0;
        bus.jump_addr       = '0;
        bus.imem_ack        = 1'b0;
        bus.imem_rdata      = '0;
    endtask

    // Entered 1 time unit after a rising edge; returns the same way.
    task automatic do_fetch(input int lat, input logic [31:0] word);
        int          cyc;
        int          stalls;
        bit          done;
        int          exp_stalls;
        logic [31:0] got;
        logic [31:0] exp;
        exp_stalls = (lat >= TIMEOUT) ? TIMEOUT - 1 : lat;
        inst_q_sb.push_back((lat >= TIMEOUT) ? NOP : word);
        if (lat >= TIMEOUT) fault_model = 1'b1;
        cyc = 0; stalls = 0; done = 1'b0;
        bus.phase_fetch = 1'b1;
        bus.imem_rdata  = word;
        while (!done && cyc < 64) begin
            bus.imem_ack = (cyc == lat);
            @(negedge clk);
            check_val("fetch_req", 32'(bus.imem_req), 32'd1);
            check_val("fetch_addr", bus.imem_addr, pc_model);
            if (bus.stall_fetch) stalls++;
            else done = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) check_val("fetch_bound", 32'd0, 32'd1);
        bus.phase_fetch = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        got = bus.inst;
        exp = inst_q_sb.pop_front();
        check_val("fetch_stalls", 32'(stalls), 32'(exp_stalls));
        check_val("fetch_inst", got, exp);
        check_val("fetch_fault", 32'(bus.fetch_fault), 32'(fault_model));
        $display("fetch pc=%08h lat=%0d stalls=%0d inst=%08h", pc_model, lat, stalls, got);
        @(posedge clk); #1;
    endtask

    task automatic do_writeback(input bit jump, input logic [31:0] target, input bit also_fetch);
        bus.phase_writeback = 1'b1;
        bus.phase_fetch     = also_fetch;
        bus.jump_en         = jump;
        bus.jump_addr       = target;
        @(negedge clk);
        if (also_fetch) begin
            check_val("both_req", 32'(bus.imem_req), 32'd0);
            check_val("both_stall", 32'(bus.stall_fetch), 32'd0);
        end
        if (jump) begin
            pc_model = {target[31:2], 2'b00};
            if (target[1:0] != 2'b00) fault_model = 1'b1;
        end else begin
            pc_model = pc_model + 32'd4;
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check_val("wb_pc", bus.pc, pc_model);
        check_val("wb_pc_plus4", bus.pc_plus4, pc_model + 32'd4);
        check_val("wb_fault", 32'(bus.fetch_fault), 32'(fault_model));
        $display("writeback jump=%0d target=%08h pc=%08h", jump, target, bus.pc);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.phase_fetch = 1'b1;
        @(negedge clk);
        check_val("rst_req", 32'(bus.imem_req), 32'd0);
        check_val("rst_stall", 32'(bus.stall_fetch), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        pc_model    = 32'h0;
        fault_model = 1'b0;
        @(negedge clk);
        check_val("rst_pc", bus.pc, 32'h0);
        check_val("rst_inst", bus.inst, NOP);
        check_val("rst_fault", 32'(bus.fetch_fault), 32'd0);
        $display("reset pc=%08h inst=%08h", bus.pc, bus.inst);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        do_fetch(0, 32'h0010_0093);
        do_fetch(3, 32'h0020_0113);

        // An ack with no outstanding request must not disturb inst.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_val("stray_req", 32'(bus.imem_req), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check_val("stray_inst", bus.inst, 32'h0020_0113);
        $display("stray ack inst=%08h", bus.inst);
        @(posedge clk); #1;

        do_writeback(1'b1, 32'h0000_0FFC, 1'b0);
        do_writeback(1'b0, 32'h0, 1'b0);
        do_writeback(1'b1, 32'hFFFF_FFFC, 1'b0);
        do_writeback(1'b0, 32'h0, 1'b0);
        do_fetch(1, 32'h0030_0193);
        do_writeback(1'b0, 32'h0, 1'b1);

        // Reset while the fetch sits in its second WAIT cycle.
        bus.phase_fetch = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_req", 32'(bus.imem_req), 32'd0);
        check_val("midrst_stall", 32'(bus.stall_fetch), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        pc_model    = 32'h0;
        fault_model = 1'b0;
        @(negedge clk);
        check_val("midrst_req2", 32'(bus.imem_req), 32'd0);
        check_val("midrst_pc", bus.pc, 32'h0);
        check_val("midrst_inst", bus.inst, NOP);
        $display("reset during wait pc=%08h inst=%08h", bus.pc, bus.inst);
        @(posedge clk); #1;
        do_fetch(0, 32'h0040_0213);

        do_fetch(NEVER, 32'h0050_0293);

        apply_reset();
        do_writeback(1'b1, 32'h0000_0102, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
